mem_port_arbiter: RTL and testbench

Shares one OBI-style memory port between the instruction-fetch requester (the `ctrl` fetch handshake: `instr_req` / `instr_gnt` / `instr_r_valid`) and the load/store data requester. The arbitration is round-robin with a lock, so a pending request is never switched away from before it is granted. An owner FIFO tracks the outstanding transactions and routes each in-order response back to the requester that issued it. The block sits between the control unit / LSU and the single-ported instruction+data memory.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/owner_fifo.sv | 82 ++++++++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
// Owner IDs tag each outstanding transaction so responses can be routed back.
package mem_arb_pkg;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    localparam int MAX_OUT_DEFAULT = 2;

    function automatic owner_t other_owner(input owner_t o);
        return (o == OWN_INSTR) ? OWN_DATA : OWN_INSTR;
    endfunction

endpackage

// File: rtl/owner_fifo.sv
// In-order FIFO of 1-bit owner IDs, one entry per granted-but-unanswered transaction.
// Push while full and pop while empty are ignored so the count stays in [0, DEPTH].
module owner_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = MAX_OUT_DEFAULT,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RES,
    input  logic             push,
    input  owner_t           push_owner,
    input  logic             pop,
    output owner_t           head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    owner_t           entry_reg [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Explicit wrap keeps non-power-of-two pointer widths (DEPTH == 1) in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = entry_reg[rd_ptr_reg];

    always_comb begin
        count_next = count_reg;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            count_reg <= count_next;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge CLK or negedge RES) begin
                if (!RES) begin
                    entry_reg[gi] <= OWN_INSTR;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg[gi] <= push_owner;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter with request lock sharing one OBI-style memory port between
// instruction fetch and load/store; an owner FIFO routes in-order responses back.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = MAX_OUT_DEFAULT,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              CLK,
    input  logic              RES,

    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_gnt,
    output logic              instr_r_valid,
    output logic [DATA_W-1:0] instr_rdata,

    input  logic              data_req,
    input  logic              data_we,
    input  logic [BE_W-1:0]   data_be,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_r_valid,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_r_valid,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    owner_t           fifo_head;

    logic   elig_instr;
    logic   elig_data;
    owner_t winner;
    logic   transfer;
    logic   resp_hit;

    logic   lock_reg;
    logic   lock_next;
    owner_t lock_owner_reg;
    owner_t lock_owner_next;
    owner_t last_owner_reg;
    owner_t last_owner_next;
    logic   err_reg;
    logic   err_next;

    // A full FIFO blocks forwarding even if a response frees a slot this cycle.
    assign elig_instr = instr_req && !fifo_full;
    assign elig_data  = data_req && !fifo_full;
    assign mem_req    = elig_instr || elig_data;
    assign transfer   = mem_req && mem_gnt;

    always_comb begin
        winner = OWN_INSTR;
        if (lock_reg) begin
            winner = lock_owner_reg;
        end else if (elig_instr && !elig_data) begin
            winner = OWN_INSTR;
        end else if (elig_data && !elig_instr) begin
            winner = OWN_DATA;
        end else if (elig_instr && elig_data) begin
            winner = other_owner(last_owner_reg);
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mem_req) begin
            if (winner == OWN_DATA) begin
                mem_we    = data_we;
                mem_be    = data_be;
                mem_addr  = data_addr;
                mem_wdata = data_wdata;
            end else begin
                mem_be    = '1;
                mem_addr  = instr_addr;
            end
        end
    end

    assign instr_gnt = transfer && (winner == OWN_INSTR);
    assign data_gnt  = transfer && (winner == OWN_DATA);

    // Responses with nothing outstanding are dropped and flagged instead of routed.
    assign resp_hit      = mem_r_valid && (fifo_count != '0);
    assign instr_r_valid = resp_hit && (fifo_head == OWN_INSTR);
    assign data_r_valid  = resp_hit && (fifo_head == OWN_DATA);
    assign instr_rdata   = mem_rdata;
    assign data_rdata    = mem_rdata;
    assign err           = err_reg;

    owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .CLK        (CLK),
        .RES        (RES),
        .push       (transfer),
        .push_owner (winner),
        .pop        (resp_hit),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    always_comb begin
        lock_next       = lock_reg;
        lock_owner_next = lock_owner_reg;
        last_owner_next = last_owner_reg;
        err_next        = err_reg || (mem_r_valid && fifo_empty);
        if (mem_req && !mem_gnt) begin
            lock_next       = 1'b1;
            lock_owner_next = winner;
        end else if (transfer) begin
            lock_next = 1'b0;
        end
        if (transfer) begin
            last_owner_next = winner;
        end
    end

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            lock_reg       <= 1'b0;
            lock_owner_reg <= OWN_INSTR;
            last_owner_reg <= OWN_INSTR;
            err_reg        <= 1'b0;
        end else begin
            lock_reg       <= lock_next;
            lock_owner_reg <= lock_owner_next;
            last_owner_reg <= last_owner_next;
            err_reg        <= err_next;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: stimulus on the falling edge, checks 1 ns later,
// expected responses queued at grant time and compared when the memory answers.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        CLK;
    logic        RES;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        instr_gnt;
    logic        instr_r_valid;
    logic [31:0] instr_rdata;
    logic        data_req;
    logic        data_we;
    logic [3:0]  data_be;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_r_valid;
    logic [31:0] data_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_r_valid;
    logic [31:0] mem_rdata;
    logic        err;

    typedef struct {
        owner_t      own;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .MAX_OUT (2)
    ) dut (
        .CLK           (CLK),
        .RES           (RES),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_gnt     (instr_gnt),
        .instr_r_valid (instr_r_valid),
        .instr_rdata   (instr_rdata),
        .data_req      (data_req),
        .data_we       (data_we),
        .data_be       (data_be),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_gnt      (data_gnt),
        .data_r_valid  (data_r_valid),
        .data_rdata    (data_rdata),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_be        (mem_be),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_r_valid   (mem_r_valid),
        .mem_rdata     (mem_rdata),
        .err           (err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        instr_req   = 1'b0;
        data_req    = 1'b0;
        mem_gnt     = 1'b0;
        mem_r_valid = 1'b0;
        mem_rdata   = '0;
    endtask

    task automatic test_reset();
        RES        = 1'b0;
        instr_addr = '0;
        data_we    = 1'b0;
        data_be    = '0;
        data_addr  = '0;
        data_wdata = '0;
        idle_inputs();
        @(negedge CLK);
        #1;
        checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, instr_gnt, data_gnt,
             instr_r_valid, data_r_valid, instr_rdata, data_rdata, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b gnt=%b%b rv=%b%b err=%b addr=%h, required all zero",
                     mem_req, instr_gnt, data_gnt, instr_r_valid, data_r_valid, err, mem_addr);
        end
        @(negedge CLK);
        RES = 1'b1;
        $display("reset: outputs idle, err=%b", err);
    endtask

    task automatic test_single_fetch();
        exp_t e;
        @(negedge CLK);
        instr_req  = 1'b1;
        instr_addr = 32'h100;
        mem_gnt    = 1'b1;
        #1;
        checks++;
        if ({instr_gnt, data_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
            {1'b1, 1'b0, 1'b1, 1'b0, 4'hf, 32'h100, 32'h0}) begin
            errors++;
            $display("FAIL fetch_grant: gnt=%b%b req=%b we=%b be=%h addr=%h wdata=%h, required 10 1 0 f 00000100 0",
                     instr_gnt, data_gnt, mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        sb.push_back('{OWN_INSTR, 32'h00500093});
        $display("fetch c0: instr_gnt=%b addr=%h", instr_gnt, mem_addr);
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++;
        if ({instr_r_valid, data_r_valid} !== 2'b00) begin
            errors++;
            $display("FAIL fetch_c1_rvalid: rv=%b%b, required 00", instr_r_valid, data_r_valid);
        end
        @(negedge CLK);
        mem_r_valid = 1'b1;
        mem_rdata   = 32'h00500093;
        #1;
        e = sb.pop_front();
        checks++;
        if ({instr_r_valid, data_r_valid} !== ((e.own == OWN_DATA) ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL fetch_resp_route: rv=%b%b, required owner %0d", instr_r_valid, data_r_valid, e.own);
        end
        checks++;
        if (instr_rdata !== e.rdata) begin
            errors++;
            $display("FAIL fetch_resp_data: rdata=%h, required %h", instr_rdata, e.rdata);
        end
        $display("fetch c2: instr_r_valid=%b rdata=%h", instr_r_valid, instr_rdata);
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_tie_alternation();
        exp_t   e;
        owner_t exp_own;
        logic [68:0] exp_pay;
        instr_addr = 32'h104;
        data_addr  = 32'h200;
        data_we    = 1'b1;
        data_be    = 4'b0011;
        data_wdata = 32'hdeadbeef;
        for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            instr_req   = (c < 3);
            data_req    = (c < 3);
            mem_gnt     = (c < 3);
            mem_r_valid = (c > 0);
            mem_rdata   = 32'h1000 + c;
            #1;
            if (c > 0) begin
                e = sb.pop_front();
                checks++;
                if ({instr_r_valid, data_r_valid} !== ((e.own == OWN_DATA) ? 2'b01 : 2'b10) ||
                    mem_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL tie_resp c%0d: rv=%b%b rdata=%h, required owner %0d rdata %h",
                             c, instr_r_valid, data_r_valid, mem_rdata, e.own, e.rdata);
                end
            end
            if (c < 3) begin
                exp_own = (c == 1) ? OWN_INSTR : OWN_DATA;
                exp_pay = (exp_own == OWN_DATA) ? {1'b1, 4'b0011, 32'h200, 32'hdeadbeef}
                                                : {1'b0, 4'hf, 32'h104, 32'h0};
                checks++;
                if ({instr_gnt, data_gnt} !== ((exp_own == OWN_DATA) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL tie_grant c%0d: gnt=%b%b, required owner %0d", c, instr_gnt, data_gnt, exp_own);
                end
                checks++;
                if ({mem_we, mem_be, mem_addr, mem_wdata} !== exp_pay) begin
                    errors++;
                    $display("FAIL tie_payload c%0d: we=%b be=%h addr=%h wdata=%h, required %h",
                             c, mem_we, mem_be, mem_addr, mem_wdata, exp_pay);
                end
                sb.push_back('{exp_own, 32'h1000 + c + 1});
            end
            $display("tie c%0d: gnt=%b%b addr=%h rv=%b%b", c, instr_gnt, data_gnt, mem_addr,
                     instr_r_valid, data_r_valid);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_lock();
        exp_t e;
        logic [1:0]  eg  [7] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b00, 2'b00};
        logic [31:0] ea  [7] = '{32'h300, 32'h300, 32'h300, 32'h300, 32'h108, 32'h0, 32'h0};
        instr_addr = 32'h108;
        data_addr  = 32'h300;
        data_we    = 1'b0;
        data_be    = 4'hf;
        data_wdata = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            instr_req   = (c >= 1 && c <= 4);
            data_req    = (c <= 3);
            mem_gnt     = (c >= 3 && c <= 4);
            mem_r_valid = (c >= 5);
            mem_rdata   = 32'h2000 + c;
            #1;
            checks++;
            if ({instr_gnt, data_gnt} !== eg[c] || mem_addr !== ea[c]) begin
                errors++;
                $display("FAIL lock_c%0d: gnt=%b%b addr=%h, required gnt=%b addr=%h",
                         c, instr_gnt, data_gnt, mem_addr, eg[c], ea[c]);
            end
            if (c == 3) sb.push_back('{OWN_DATA, 32'h2005});
            if (c == 4) sb.push_back('{OWN_INSTR, 32'h2006});
            if (c >= 5) begin
                e = sb.pop_front();
                checks++;
                if ({instr_r_valid, data_r_valid} !== ((e.own == OWN_DATA) ? 2'b01 : 2'b10) ||
                    mem_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL lock_resp c%0d: rv=%b%b rdata=%h, required owner %0d rdata %h",
                             c, instr_r_valid, data_r_valid, mem_rdata, e.own, e.rdata);
                end
            end
            $display("lock c%0d: gnt=%b%b addr=%h rv=%b%b", c, instr_gnt, data_gnt, mem_addr,
                     instr_r_valid, data_r_valid);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_full();
        exp_t e;
        logic        er [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0]  eg [7] = '{2'b10, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00};
        for (int c = 0; c < 7; c++) begin
            @(negedge CLK);
            instr_req   = (c == 0) || (c >= 2 && c <= 4);
            data_req    = (c >= 1 && c <= 4);
            mem_gnt     = (c <= 4);
            mem_r_valid = (c == 3) || (c >= 5);
            mem_rdata   = 32'h3000 + c;
            #1;
            checks++;
            if (mem_req !== er[c] || {instr_gnt, data_gnt} !== eg[c]) begin
                errors++;
                $display("FAIL full_c%0d: mem_req=%b gnt=%b%b, required mem_req=%b gnt=%b",
                         c, mem_req, instr_gnt, data_gnt, er[c], eg[c]);
            end
            if (mem_r_valid) begin
                e = sb.pop_front();
                checks++;
                if ({instr_r_valid, data_r_valid} !== ((e.own == OWN_DATA) ? 2'b01 : 2'b10) ||
                    mem_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL full_resp c%0d: rv=%b%b rdata=%h, required owner %0d rdata %h",
                             c, instr_r_valid, data_r_valid, mem_rdata, e.own, e.rdata);
                end
            end
            if (c == 0) sb.push_back('{OWN_INSTR, 32'h3003});
            if (c == 1) sb.push_back('{OWN_DATA, 32'h3005});
            if (c == 4) sb.push_back('{OWN_INSTR, 32'h3006});
            $display("full c%0d: mem_req=%b gnt=%b%b rv=%b%b", c, mem_req, instr_gnt, data_gnt,
                     instr_r_valid, data_r_valid);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    task automatic test_spurious();
        @(negedge CLK);
        mem_r_valid = 1'b1;
        mem_rdata   = 32'hbad;
        #1;
        checks++;
        if ({instr_r_valid, data_r_valid, err} !== 3'b000) begin
            errors++;
            $display("FAIL spurious_c0: rv=%b%b err=%b, required 00 err=0", instr_r_valid, data_r_valid, err);
        end
        for (int c = 1; c < 3; c++) begin
            @(negedge CLK);
            idle_inputs();
            #1;
            checks++;
            if (err !== 1'b1) begin
                errors++;
                $display("FAIL spurious_err_c%0d: err=%b, required 1", c, err);
            end
            $display("spurious c%0d: err=%b", c, err);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        @(negedge CLK);
        RES = 1'b0;
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_err_clear: err=%b, required 0", err);
        end
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        instr_req  = 1'b1;
        instr_addr = 32'h10c;
        mem_gnt    = 1'b1;
        #1;
        checks++;
        if (instr_gnt !== 1'b1) begin
            errors++;
            $display("FAIL midrst_grant: instr_gnt=%b, required 1", instr_gnt);
        end
        @(negedge CLK);
        idle_inputs();
        RES = 1'b0;
        @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        mem_r_valid = 1'b1;
        mem_rdata   = 32'h4444;
        #1;
        checks++;
        if ({instr_r_valid, data_r_valid} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_late_resp: rv=%b%b, required 00", instr_r_valid, data_r_valid);
        end
        @(negedge CLK);
        idle_inputs();
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL midrst_err: err=%b, required 1", err);
        end
        $display("midrst: late response dropped, err=%b", err);
        // Empty FIFO after reset: exactly two grants fit before mem_req drops.
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            instr_req   = (c == 0) || (c == 2);
            data_req    = (c == 1);
            mem_gnt     = (c <= 2);
            mem_r_valid = (c >= 3);
            mem_rdata   = 32'h5000 + c;
            #1;
            checks++;
            if (mem_req !== (c < 2) || {instr_gnt, data_gnt} !== ((c == 0) ? 2'b10 : (c == 1) ? 2'b01 : 2'b00)) begin
                errors++;
                $display("FAIL midrst_fill_c%0d: mem_req=%b gnt=%b%b", c, mem_req, instr_gnt, data_gnt);
            end
            if (c == 0) sb.push_back('{OWN_INSTR, 32'h5003});
            if (c == 1) sb.push_back('{OWN_DATA, 32'h5004});
            if (c >= 3) begin
                e = sb.pop_front();
                checks++;
                if ({instr_r_valid, data_r_valid} !== ((e.own == OWN_DATA) ? 2'b01 : 2'b10) ||
                    mem_rdata !== e.rdata) begin
                    errors++;
                    $display("FAIL midrst_resp c%0d: rv=%b%b rdata=%h, required owner %0d rdata %h",
                             c, instr_r_valid, data_r_valid, mem_rdata, e.own, e.rdata);
                end
            end
            $display("midrst fill c%0d: mem_req=%b gnt=%b%b rv=%b%b", c, mem_req, instr_gnt, data_gnt,
                     instr_r_valid, data_r_valid);
        end
        @(negedge CLK);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_tie_alternation();
        test_lock();
        test_full();
        test_spurious();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
